// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: control bundle plus LANES data words, 2-entry skid buffer, flush bubble.
// Optional stall counter port (stall_cnt, CNT_W) is built when PIPE_STAGE_STALL_CNT_EN is defined.
module pipeline_stage_reg #(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 32,
    parameter int LANES     = 3,
    parameter int GATE_CTRL = 1
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt
`endif
);

    localparam int DW = LANES * DATA_W;

    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     main_data;
    logic [DW-1:0]     skid_data;
    logic              acc;
    logic              drn;

    // Handshake: a beat moves on an edge where valid and ready are both high on that side.
    // in_ready depends only on the skid register, so there is no ready path from out_ready to in_ready.
    assign in_ready  = !skid_valid;
    assign acc       = in_valid && in_ready;
    assign drn       = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = (GATE_CTRL != 0 && !main_valid) ? '0 : main_ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Bubble: control is zeroed so a killed beat can never leak write enables; data holds.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else if (!main_valid || drn) begin
            if (skid_valid) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc) begin
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Saturating count of stalled cycles; deliberately survives flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: streaming, back-pressure, flush, async reset, lane mapping,
// and the saturating stall counter when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipeline_stage_reg;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   in_ctrl;
    logic [7:0]   out_ctrl;
    logic [95:0]  in_data;
    logic [95:0]  out_data;

    logic         in_ready_b;
    logic         out_valid_b;
    logic [11:0]  in_ctrl_b;
    logic [11:0]  out_ctrl_b;
    logic [127:0] in_data_b;
    logic [127:0] out_data_b;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [3:0]   stall_cnt;
    logic [3:0]   stall_cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    pipeline_stage_reg #(
        .CTRL_W(8), .DATA_W(32), .LANES(3), .GATE_CTRL(1)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipeline_stage_reg #(
        .CTRL_W(12), .DATA_W(32), .LANES(4), .GATE_CTRL(1)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .CNT_W(4)
`endif
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt_b)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk_data(input int v);
        return {32'(v * 256 + 2), 32'(v * 16 + 1), 32'(v)};
    endfunction

    function automatic logic [127:0] mk_data_b(input int v);
        return {32'(v + 300), 32'(v + 200), 32'(v + 100), 32'(v)};
    endfunction

    task automatic drive(input int v);
        in_valid  = 1'b1;
        in_ctrl   = 8'(v);
        in_data   = mk_data(v);
        in_ctrl_b = 12'(v + 12'h100);
        in_data_b = mk_data_b(v);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        int nxt;
        int valid_cycles;
        logic accepted;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_ctrl_b = '0;
        in_data_b = '0;

        // reset state
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        reset_n = 1'b1;

        // streaming, one-cycle latency, both parameter sets
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_ctrl", out_ctrl, 128'(i));
            check("stream_data", out_data, mk_data(i));
            check("stream_in_ready", in_ready, 1);
            check("stream_b_ctrl", out_ctrl_b, 128'(i + 12'h100));
            check("stream_b_data", out_data_b, mk_data_b(i));
        end
        idle();
        tick();
        check("stream_drained", out_valid, 0);
        check("stream_gated_ctrl", out_ctrl, 0);

        // back-pressure into the skid entry, then ordered release
        exp_q = {8'd11, 8'd12, 8'd13, 8'd14};
        out_ready = 1'b0;
        drive(11);
        tick();
        check("bp_main_valid", out_valid, 1);
        check("bp_ready_one", in_ready, 1);
        drive(12);
        tick();
        check("bp_skid_full", in_ready, 0);
        check("bp_b_skid_full", in_ready_b, 0);
        drive(8'hee);
        tick();
        check("bp_hold_ctrl", out_ctrl, 11);
        check("bp_hold_ready", in_ready, 0);
        drive(13);
        nxt = 13;
        out_ready = 1'b1;
        valid_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                valid_cycles++;
                if (exp_q.size() > 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("bp_order_ctrl", out_ctrl, 128'(e));
                    check("bp_order_data", out_data, mk_data(int'(e)));
                end else begin
                    check("bp_extra_beat", out_valid, 0);
                end
            end
            accepted = in_valid && in_ready;
            tick();
            if (accepted) begin
                nxt++;
                if (nxt > 14) idle();
                else drive(nxt);
            end
        end
        check("bp_all_seen", 128'(exp_q.size()), 0);
        check("bp_no_gaps", 128'(valid_cycles), 4);

        // flush with skid full and an incoming beat offered
        out_ready = 1'b0;
        drive(21);
        tick();
        drive(22);
        tick();
        check("fl_pre_skid", in_ready, 0);
        drive(23);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        // flush discards a beat accepted in the same cycle
        drive(24);
        tick();
        drive(25);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        check("fl_acc_dropped", out_valid, 0);
        tick();
        check("fl_no_ghost", out_valid, 0);
        drive(26);
        tick();
        idle();
        check("fl_recover_valid", out_valid, 1);
        check("fl_recover_ctrl", out_ctrl, 26);
        tick();

        // asynchronous reset between edges while stalled
        out_ready = 1'b0;
        drive(31);
        tick();
        drive(32);
        tick();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_ctrl", out_ctrl, 0);
        check("ar_out_data", out_data, 0);
        check("ar_in_ready", in_ready, 1);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("ar_stall_cnt", stall_cnt, 0);
`endif
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        drive(33);
        tick();
        idle();
        check("ar_first_accept", out_ctrl, 33);
        tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
        // saturating stall counter, untouched by flush
        out_ready = 1'b0;
        drive(41);
        tick();
        idle();
        repeat (20) tick();
        check("sc_saturated", stall_cnt, 15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sc_after_flush", stall_cnt, 15);
        out_ready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
